register_file_scoreboard: RTL
=============================

Name: register_file_scoreboard

Overview:
Parametrised successor to the CPU general-purpose register file: configurable data width and register count, two combinational read ports with optional write-to-read bypass, and a per-register pending-write scoreboard. Multicycle producers (loads, mult/div results) reserve their destination at issue and release it on writeback, so the decode stage can detect RAW hazards from the read_pendingN outputs. Sits between decode (reads, reserve) and writeback (write, release); keeps the register_v0 debug output used by the testbench.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports
ADDR_WIDTH, 5, index width; register count is 2**ADDR_WIDTH
HARDWIRED_ZERO, 1, 1: register 0 reads 0, ignores writes, never reserved
BYPASS, 1, 1: same-cycle write data and release are visible on the read ports
PEND_WIDTH, 2, width of each per-register pending counter (max outstanding = 2**PEND_WIDTH-1)
V0_INDEX, 2, register driven onto register_v0

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all registers, counters and flags
read_index1  input  ADDR_WIDTH  read port 1 index
read_index2  input  ADDR_WIDTH  read port 2 index
read_data1  output  DATA_WIDTH  read port 1 data (combinational)
read_data2  output  DATA_WIDTH  read port 2 data (combinational)
read_pending1  output  1  register at read_index1 has an outstanding reservation
read_pending2  output  1  register at read_index2 has an outstanding reservation
write_enable  input  1  write write_data to write_reg this cycle
write_reg  input  ADDR_WIDTH  write index
write_data  input  DATA_WIDTH  write data
write_release  input  1  this write retires one reservation on write_reg; qualified by write_enable
reserve_enable  input  1  add one reservation on reserve_reg
reserve_reg  input  ADDR_WIDTH  reserve index
reserve_full  output  1  counter of reserve_reg is at maximum (combinational)
scoreboard_error  output  1  sticky: release on zero count or reserve when full
register_v0  output  DATA_WIDTH  current contents of register V0_INDEX (no bypass)

Behaviour:
- Reset asserted (any time, including mid-transaction): registers, counters and scoreboard_error go to 0 immediately; read_data, read_pending and register_v0 read 0. First write is accepted on the first rising edge after deassertion.
- Write: on a rising edge with write_enable=1, register[write_reg] <= write_data. Ignored for index 0 when HARDWIRED_ZERO=1.
- Read: read_dataN = 0 if HARDWIRED_ZERO and index=0. Otherwise, if BYPASS and write_enable and write_reg==indexN, then write_data. Otherwise register[indexN]. Zero latency.
- Counter update per edge, for register r:
  - inc = reserve_enable & reserve_reg==r.
  - dec = write_enable & write_release & write_reg==r.
  - inc & dec: count unchanged.
  - inc only: count+1 if count<max; else unchanged and scoreboard_error<=1.
  - dec only: count-1 if count>0; else unchanged and scoreboard_error<=1 (the write still happens).
  - HARDWIRED_ZERO=1: register 0 counter is held at 0; inc/dec on it is ignored and raises no error.
- read_pendingN:
  - count[indexN]!=0.
  - With BYPASS=1, a same-cycle release to indexN with count==1 (and no same-cycle reserve) gives pending=0, consistent with the bypassed data.
  - Always 0 for index 0 when HARDWIRED_ZERO=1.
- reserve_full: count[reserve_reg]==max. This is a combinational lookahead; the issuing stage must stall rather than reserve while it is high.
- Simultaneous reserve and write to the same register without release: the write lands and the count increments. The reservation is for the later producer.
- scoreboard_error clears only on reset.
- register_v0 = register[V0_INDEX], with no bypass.
- No $display in synthesisable path; debug prints guarded by `ifndef SYNTHESIS.

Test Plan:
- Async reset: write 0xDEADBEEF to r5, assert reset between clock edges -> read_data1 (index 5) = 0 and register_v0 = 0 before the next edge; scoreboard_error = 0.
- r0 hardwired: write 0x12345678 to r0 with release, reserve r0 -> read_data1 = 0, read_pending1 = 0, scoreboard_error stays 0.
- Bypass: write 0xCAFEF00D to r7 with read_index1=read_index2=7 in the same cycle -> both read ports show 0xCAFEF00D in that cycle. With BYPASS=0 they show the old value 0 until the next cycle.
- Scoreboard:
  - Reserve r3 twice -> read_pending2 = 1.
  - Write 0x11 with release -> still pending.
  - Write 0x22 with release -> pending drops in the same cycle (BYPASS=1) and read_data2 = 0x22.
- Saturation/error:
  - Reserve r9 three times (PEND_WIDTH=2) -> reserve_full = 1.
  - Fourth reserve -> count stays 3, scoreboard_error = 1.
  - Release on r10 with count 0 -> write lands, error stays 1.
- Simultaneous reserve and release on r4 with count 1 -> count stays 1 and read_pending stays 1. Parameter sweep with DATA_WIDTH=64, ADDR_WIDTH=6: write/read r63 = 0xFFFF_0000_FFFF_0000.

Source files
------------

// File: rtl/register_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : register_file_scoreboard
// Brief    : Parametrised register file with two combinational read ports,
//            optional write-to-read bypass and a per-register pending-write
//            scoreboard for RAW hazard detection.
// Revision : 1.0
// ============================================================================
module register_file_scoreboard #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int HARDWIRED_ZERO = 1,
    parameter int BYPASS         = 1,
    parameter int PEND_WIDTH     = 2,
    parameter int V0_INDEX       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_index1,
    input  logic [ADDR_WIDTH-1:0] read_index2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic                  read_pending1,
    output logic                  read_pending2,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_release,
    input  logic                  reserve_enable,
    input  logic [ADDR_WIDTH-1:0] reserve_reg,
    output logic                  reserve_full,
    output logic                  scoreboard_error,
    output logic [DATA_WIDTH-1:0] register_v0
);

    localparam int                    c_NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [PEND_WIDTH-1:0] c_PEND_MAX = {PEND_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] regs_q  [c_NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d  [c_NUM_REGS];
    logic [PEND_WIDTH-1:0] count_q [c_NUM_REGS];
    logic [PEND_WIDTH-1:0] count_d [c_NUM_REGS];
    logic                  err_q;
    logic                  err_d;

    always_comb begin
        regs_d = regs_q;
        if (write_enable && !(HARDWIRED_ZERO != 0 && write_reg == '0)) begin
            regs_d[write_reg] = write_data;
        end
    end

    // Reserve and release on the same register cancel; saturation and
    // underflow leave the count alone and latch the error flag.
    always_comb begin
        logic inc;
        logic dec;
        count_d = count_q;
        err_d   = err_q;
        inc     = 1'b0;
        dec     = 1'b0;
        for (int r = 0; r < c_NUM_REGS; r++) begin
            inc = reserve_enable && (reserve_reg == ADDR_WIDTH'(r));
            dec = write_enable && write_release && (write_reg == ADDR_WIDTH'(r));
            if (HARDWIRED_ZERO != 0 && r == 0) begin
                count_d[r] = '0;
            end else if (inc && !dec) begin
                if (count_q[r] == c_PEND_MAX) err_d = 1'b1;
                else                          count_d[r] = count_q[r] + 1'b1;
            end else if (dec && !inc) begin
                if (count_q[r] == '0) err_d = 1'b1;
                else                  count_d[r] = count_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q  <= '{default: '0};
            count_q <= '{default: '0};
            err_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] idx);
        logic [DATA_WIDTH-1:0] v;
        v = regs_q[idx];
        if (BYPASS != 0 && write_enable && write_reg == idx) v = write_data;
        if (HARDWIRED_ZERO != 0 && idx == '0)                v = '0;
        return v;
    endfunction

    // A bypassed final release clears pending in the same cycle, so decode
    // sees data and hazard status that agree.
    function automatic logic pending_of(input logic [ADDR_WIDTH-1:0] idx);
        logic p;
        p = (count_q[idx] != '0);
        if (BYPASS != 0 && write_enable && write_release && write_reg == idx &&
            count_q[idx] == PEND_WIDTH'(1) && !(reserve_enable && reserve_reg == idx)) begin
            p = 1'b0;
        end
        if (HARDWIRED_ZERO != 0 && idx == '0) p = 1'b0;
        return p;
    endfunction

    always_comb begin
        read_data1       = read_value(read_index1);
        read_data2       = read_value(read_index2);
        read_pending1    = pending_of(read_index1);
        read_pending2    = pending_of(read_index2);
        reserve_full     = (count_q[reserve_reg] == c_PEND_MAX);
        scoreboard_error = err_q;
        register_v0      = regs_q[ADDR_WIDTH'(V0_INDEX)];
    end

endmodule
`default_nettype wire
